// File: rtl/spiht_line_capture.sv
// spiht_line_capture: HSYNC-qualified line capture into a ping-pong buffer with a ready/release handshake.
// Define SPIHT_CAPTURE_SUM_EN to build the per-frame pixel checksum on frame_sum.
module spiht_line_capture #(
    parameter int IMG_WIDTH  = 2048,
    parameter int IMG_HEIGHT = 2048,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Pixel_DATA,
    input  logic              HSYNC,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              line_done,
    output logic              line_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] line_num,
    output logic              frame_end,
    output logic              short_err,
    output logic              long_err,
    output logic              ovf_err,
    output logic [31:0]       frame_sum
);
    localparam logic [ADDR_W:0]   W_LEN  = (ADDR_W+1)'(IMG_WIDTH);
    localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;

    w_state_t          r_state;
    logic              r_hsync_d;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [1:0]        r_full;
    logic [ADDR_W-1:0] r_tag [2];
    logic [ADDR_W:0]   r_wr_cnt;
    logic [ADDR_W-1:0] r_line_cnt;
    logic [DATA_W-1:0] r_mem [2**(ADDR_W+1)];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_frame_end;
    logic              r_short_err;
    logic              r_long_err;
    logic              r_ovf_err;

    logic       w_rise, w_fall, w_start, w_wr, w_commit, w_short, w_release;
    logic [1:0] w_set, w_clr;

    assign w_rise    = HSYNC & ~r_hsync_d;
    assign w_fall    = ~HSYNC & r_hsync_d;
    assign w_start   = (r_state == W_IDLE) & w_rise & ~r_full[r_wr_bank];
    // wr_cnt is 0 whenever the FSM is idle, so it doubles as the write address
    assign w_wr      = w_start | ((r_state == W_FILL) & HSYNC & (r_wr_cnt != W_LEN));
    assign w_commit  = (r_state == W_FILL) & w_fall & (r_wr_cnt == W_LEN);
    assign w_short   = (r_state == W_FILL) & w_fall & (r_wr_cnt != W_LEN);
    assign w_release = line_done & r_full[r_rd_bank];
    assign w_set     = w_commit ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr     = w_release ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge PCLK)
        if (w_wr) r_mem[{r_wr_bank, r_wr_cnt[ADDR_W-1:0]}] <= Pixel_DATA;

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_state     <= W_IDLE;
            r_hsync_d   <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_full      <= 2'b00;
            r_tag       <= '{default: '0};
            r_wr_cnt    <= '0;
            r_line_cnt  <= '0;
            r_rd_data   <= '0;
            r_frame_end <= 1'b0;
            r_short_err <= 1'b0;
            r_long_err  <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_hsync_d   <= HSYNC;
            r_full      <= (r_full & ~w_clr) | w_set;
            r_rd_data   <= r_mem[{r_rd_bank, rd_addr}];
            r_frame_end <= w_commit & (r_line_cnt == H_LAST);
            if (w_release) r_rd_bank <= ~r_rd_bank;
            if (w_commit) begin
                r_tag[r_wr_bank] <= r_line_cnt;
                r_wr_bank        <= ~r_wr_bank;
                r_line_cnt       <= (r_line_cnt == H_LAST) ? '0 : r_line_cnt + 1'b1;
            end
            if (w_short) r_short_err <= 1'b1;
            if (w_wr) r_wr_cnt <= r_wr_cnt + 1'b1;
            case (r_state)
                W_IDLE: if (w_rise) begin
                    r_state <= r_full[r_wr_bank] ? W_DROP : W_FILL;
                    if (r_full[r_wr_bank]) r_ovf_err <= 1'b1;
                end
                W_FILL: begin
                    if (HSYNC && r_wr_cnt == W_LEN) r_long_err <= 1'b1;
                    if (w_fall) begin
                        r_state  <= W_IDLE;
                        r_wr_cnt <= '0;
                    end
                end
                W_DROP:  if (w_fall) r_state <= W_IDLE;
                default: r_state <= W_IDLE;
            endcase
        end
    end

`ifdef SPIHT_CAPTURE_SUM_EN
    logic [31:0] r_acc;
    logic [31:0] r_snap;
    logic [31:0] r_frame_sum;

    // snapshot at line start lets a short line be rolled back out of the total
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_acc       <= '0;
            r_snap      <= '0;
            r_frame_sum <= '0;
        end else begin
            if (w_start) r_snap <= r_acc;
            if (w_short) r_acc <= r_snap;
            else if (w_commit && r_line_cnt == H_LAST) begin
                r_frame_sum <= r_acc;
                r_acc       <= '0;
            end else if (w_wr) r_acc <= r_acc + 32'(Pixel_DATA);
        end
    end

    assign frame_sum = r_frame_sum;
`else
    assign frame_sum = 32'd0;
`endif

    assign line_rdy  = r_full[r_rd_bank];
    assign line_num  = r_tag[r_rd_bank];
    assign rd_data   = r_rd_data;
    assign frame_end = r_frame_end;
    assign short_err = r_short_err;
    assign long_err  = r_long_err;
    assign ovf_err   = r_ovf_err;
endmodule

// File: tb/tb_spiht_line_capture.sv
// tb_spiht_line_capture: directed line/frame stimulus; read data and frame pulses checked by a queue-based monitor.
module tb_spiht_line_capture;
    localparam int W = 2048;
`ifdef SPIHT_CAPTURE_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        RST = 1'b1;
    logic        HSYNC = 1'b0;
    logic        line_done = 1'b0;
    logic [15:0] Pixel_DATA = '0;
    logic [10:0] rd_addr = '0;
    logic        line_rdy, frame_end, short_err, long_err, ovf_err;
    logic [15:0] rd_data;
    logic [10:0] line_num;
    logic [31:0] frame_sum;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] rd_q[$];
    logic [31:0] fe_q[$];
    logic        rd_vld = 1'b0;
    int          lc = 0;
    logic [31:0] fsum = '0;

    spiht_line_capture #(.IMG_HEIGHT(4)) dut (
        .PCLK(PCLK), .RST(RST), .Pixel_DATA(Pixel_DATA), .HSYNC(HSYNC),
        .rd_addr(rd_addr), .line_done(line_done), .line_rdy(line_rdy),
        .rd_data(rd_data), .line_num(line_num), .frame_end(frame_end),
        .short_err(short_err), .long_err(long_err), .ovf_err(ovf_err),
        .frame_sum(frame_sum)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (rd_vld) begin
            if (rd_q.size() == 0) chk("rd_q_nonempty", 32'(rd_q.size()), 1);
            else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
        if (frame_end === 1'b1) begin
            if (fe_q.size() == 0) chk("frame_end_unexpected", 32'(frame_end), 0);
            else chk("frame_sum", frame_sum, fe_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send_line(input int n, input logic [15:0] base, input bit commit);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] p;
            p = base + 16'(i);
            tick();
            HSYNC = 1'b1;
            Pixel_DATA = p;
            if (i < W) s += 32'(p);
        end
        if (commit) begin
            fsum += s;
            if (lc == 3) begin
                fe_q.push_back(SUM_EN ? fsum : 32'd0);
                fsum = '0;
                lc = 0;
            end else lc++;
        end
        tick();
        HSYNC = 1'b0;
        Pixel_DATA = '0;
        repeat (3) tick();
    endtask

    task automatic rd(input logic [10:0] a, input logic [15:0] e);
        tick();
        rd_addr = a;
        rd_q.push_back(e);
        tick();
        rd_vld = 1'b1;
        tick();
        rd_vld = 1'b0;
    endtask

    task automatic release_line();
        tick();
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
    endtask

    task automatic st(input string n, input bit rdy, input int num);
        @(negedge PCLK);
        chk({n, "_line_rdy"}, 32'(line_rdy), 32'(rdy));
        chk({n, "_line_num"}, 32'(line_num), num);
    endtask

    task automatic errs(input string n, input bit s, input bit l, input bit o);
        @(negedge PCLK);
        chk({n, "_short_err"}, 32'(short_err), 32'(s));
        chk({n, "_long_err"}, 32'(long_err), 32'(l));
        chk({n, "_ovf_err"}, 32'(ovf_err), 32'(o));
    endtask

    task automatic chk_zero(input string n);
        @(negedge PCLK);
        chk({n, "_line_rdy"}, 32'(line_rdy), 0);
        chk({n, "_rd_data"}, 32'(rd_data), 0);
        chk({n, "_line_num"}, 32'(line_num), 0);
        chk({n, "_frame_end"}, 32'(frame_end), 0);
        chk({n, "_frame_sum"}, frame_sum, 0);
        errs(n, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        chk_zero("reset");
        tick();
        RST = 1'b0;
        send_line(W, 16'h0000, 1'b1);
        send_line(W, 16'h1000, 1'b1);
        st("t1", 1'b1, 0);
        rd(11'd5, 16'h0005);
        rd(11'd2047, 16'h07FF);
        release_line();
        st("t2a", 1'b1, 1);
        rd(11'd5, 16'h1005);
        release_line();
        st("t2b", 1'b0, 0);
        send_line(W, 16'h2000, 1'b1);
        send_line(W, 16'h3000, 1'b1);
        send_line(W, 16'h4000, 1'b0);
        errs("t3", 1'b0, 1'b0, 1'b1);
        st("t3a", 1'b1, 2);
        release_line();
        st("t3b", 1'b1, 3);
        send_line(W, 16'h5000, 1'b1);
        release_line();
        st("t3c", 1'b1, 0);
        rd(11'd5, 16'h5005);
        release_line();
        st("t3d", 1'b0, 3);
        send_line(2000, 16'h6000, 1'b0);
        errs("t4a", 1'b1, 1'b0, 1'b1);
        st("t4a", 1'b0, 3);
        send_line(W, 16'h7000, 1'b1);
        st("t4b", 1'b1, 1);
        rd(11'd5, 16'h7005);
        rd(11'd2001, 16'h77D1);
        release_line();
        st("t4c", 1'b0, 0);
        send_line(W + 1, 16'h8000, 1'b1);
        errs("t5", 1'b1, 1'b1, 1'b1);
        st("t5", 1'b1, 2);
        rd(11'd2047, 16'h87FF);
        rd(11'd0, 16'h8000);
        release_line();
        st("t5b", 1'b0, 1);
        tick();
        RST = 1'b1;
        lc = 0;
        fsum = '0;
        chk_zero("rst2");
        tick();
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_line(W, 16'(32'h9000 + k * 256), 1'b1);
            st($sformatf("t6_line%0d", k), 1'b1, k);
            release_line();
        end
        for (int i = 0; i < 500; i++) begin
            tick();
            HSYNC = 1'b1;
            Pixel_DATA = 16'(i);
        end
        tick();
        RST = 1'b1;
        HSYNC = 1'b0;
        chk_zero("midline");
        tick();
        RST = 1'b0;
        repeat (20) tick();
        chk_zero("post_rst");
        chk("fe_q_drained", 32'(fe_q.size()), 0);
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
